// File: rtl/wrap_supply_seq.sv
// wrap_supply_seq
//   Simulation supply/tie model with power sequencing. Drives constant
//   ground and tie banks, and on request brings up the IO rail, then the core
//   rail, then releases core reset. Power-down runs in reverse order. A drop
//   of pwr_req during power-up aborts into the matching power-down step.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   pwr_req   in   1 = request powered, 0 = request off
//   vdd_io    out  IO supply (registered)
//   vdd_co    out  core supply (registered)
//   vss       out  ground, constant 0
//   netTie0   out  N_TIE0 bits, constant 0
//   netTie1   out  N_TIE1 bits, constant 1
//   core_rst  out  core reset, active-high (registered)
//   pwr_good  out  both rails up and core released (registered)
//   busy      out  sequence in progress (combinational)

module wrap_supply_seq #(
  parameter int N_TIE0 = 1,
  parameter int N_TIE1 = 1,
  parameter int IO_DLY = 4,
  parameter int CO_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwr_req,
  output logic              vdd_io,
  output logic              vdd_co,
  output logic              vss,
  output logic [N_TIE0-1:0] netTie0,
  output logic [N_TIE1-1:0] netTie1,
  output logic              core_rst,
  output logic              pwr_good,
  output logic              busy
);

  localparam int MAX_DLY = (IO_DLY > CO_DLY) ? IO_DLY : CO_DLY;
  localparam int CW      = $clog2(MAX_DLY + 1);
  localparam logic [CW-1:0] IO_LAST = CW'(IO_DLY - 1);
  localparam logic [CW-1:0] CO_LAST = CW'(CO_DLY - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_IO_UP,
    S_CO_UP,
    S_ON,
    S_CO_DN,
    S_IO_DN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          io_nxt, co_nxt, crst_nxt, good_nxt;

  assign vss     = 1'b0;
  assign netTie0 = '0;
  assign netTie1 = '1;
  assign busy    = (state != S_OFF) && (state != S_ON);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OFF;
      cnt      <= '0;
      vdd_io   <= 1'b0;
      vdd_co   <= 1'b0;
      core_rst <= 1'b1;
      pwr_good <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vdd_io   <= io_nxt;
      vdd_co   <= co_nxt;
      core_rst <= crst_nxt;
      pwr_good <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    io_nxt    = vdd_io;
    co_nxt    = vdd_co;
    crst_nxt  = core_rst;
    good_nxt  = pwr_good;
    unique case (state)
      S_OFF: begin
        if (pwr_req) begin
          io_nxt    = 1'b1;
          state_nxt = S_IO_UP;
        end
      end
      S_IO_UP: begin
        cnt_nxt = cnt + 1'b1;
        // Abort wins over step completion; the IO rail stays up until the
        // IO down-step has run its full delay.
        if (!pwr_req) begin
          state_nxt = S_IO_DN;
        end else if (cnt == IO_LAST) begin
          co_nxt    = 1'b1;
          state_nxt = S_CO_UP;
        end
      end
      S_CO_UP: begin
        cnt_nxt = cnt + 1'b1;
        if (!pwr_req) begin
          state_nxt = S_CO_DN;
        end else if (cnt == CO_LAST) begin
          crst_nxt  = 1'b0;
          good_nxt  = 1'b1;
          state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (!pwr_req) begin
          crst_nxt  = 1'b1;
          good_nxt  = 1'b0;
          state_nxt = S_CO_DN;
        end
      end
      S_CO_DN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CO_LAST) begin
          co_nxt    = 1'b0;
          state_nxt = S_IO_DN;
        end
      end
      S_IO_DN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == IO_LAST) begin
          io_nxt    = 1'b0;
          state_nxt = S_OFF;
        end
      end
      default: begin
        state_nxt = S_OFF;
      end
    endcase
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

endmodule
